gate_bist_checker: RTL and testbench

Hardware counterpart to a truth-table testbench: a self-test sequencer for a small combinational gate under test (GUT).
- Drives every input combination onto the GUT in ascending binary order.
- Holds each combination for a programmable settle time, then samples the GUT output and compares it against a parameterised expected truth table.
- Reports done, pass/fail, error count and first failing vector.
- Sits beside any gate block in the logic-gates area as an on-chip checker.

---
 rtl/bist_pkg.sv | 23 ++
 rtl/gate_bist_checker_dwell_timer.sv | 32 +++
 rtl/gate_bist_checker.sv | 127 ++++++++++++
 tb/tb_gate_bist_checker.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// +----------------------------------------------------------------------+
// | bist_pkg : shared types and helpers for gate_bist_checker    rev 1.0 |
// +----------------------------------------------------------------------+
`default_nettype none

package bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DWELL_W = 8;

  function automatic int num_vec(input int n);
    return 1 << n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gate_bist_checker_dwell_timer.sv
// +----------------------------------------------------------------------+
// | dwell_timer : clearable settle counter, expired at DWELL-1   rev 1.0 |
// +----------------------------------------------------------------------+
`default_nettype none

module dwell_timer
  import bist_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [DWELL_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + DWELL_W'(1);
    end
  end

  assign expired = (count == DWELL_W'(DWELL - 1));

endmodule

`default_nettype wire

// File: rtl/gate_bist_checker.sv
// +----------------------------------------------------------------------+
// | gate_bist_checker : exhaustive truth-table self-test of a gate       |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module gate_bist_checker
  import bist_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter     TRUTH = 4'b1110,
  parameter int DWELL = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            dut_o,
  output logic [N_IN-1:0] dut_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err_idx,
  output logic            first_err_valid
);

  localparam int                   NUM_VEC = num_vec(N_IN);
  localparam logic [NUM_VEC-1:0]   TRUTH_V = TRUTH;

  generate
    if (DWELL < 1 || DWELL > 255 || $bits(TRUTH) != NUM_VEC) begin : g_param_check
      $fatal(1, "gate_bist_checker: illegal DWELL or TRUTH width");
    end
  endgenerate

  state_t          state, state_nx;
  logic [N_IN-1:0] dut_in_nx;
  logic            busy_nx, done_nx, pass_nx;
  logic [N_IN:0]   err_nx, err_sum;
  logic [N_IN-1:0] fidx_nx;
  logic            fval_nx;
  logic            mismatch;
  logic            expired;

  dwell_timer #(.DWELL(DWELL)) u_dwell_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state != SETTLE),
    .en      (state == SETTLE),
    .expired (expired)
  );

  always_comb begin
    state_nx  = state;
    dut_in_nx = dut_in;
    busy_nx   = busy;
    done_nx   = done;
    pass_nx   = pass;
    err_nx    = err_count;
    fidx_nx   = first_err_idx;
    fval_nx   = first_err_valid;
    // Equality with X/Z on dut_o is not true, so such samples fall to mismatch.
    if (dut_o == TRUTH_V[dut_in]) mismatch = 1'b0;
    else                          mismatch = 1'b1;
    err_sum = err_count + (N_IN+1)'(mismatch);

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx  = SETTLE;
          dut_in_nx = '0;
          busy_nx   = 1'b1;
          done_nx   = 1'b0;
          pass_nx   = 1'b0;
          err_nx    = '0;
          fidx_nx   = '0;
          fval_nx   = 1'b0;
        end
      end
      SETTLE: begin
        if (expired) state_nx = SAMPLE;
      end
      SAMPLE: begin
        err_nx = err_sum;
        if (mismatch && !first_err_valid) begin
          fidx_nx = dut_in;
          fval_nx = 1'b1;
        end
        if (&dut_in) begin
          state_nx = DONE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          pass_nx  = (err_sum == '0);
        end else begin
          state_nx  = SETTLE;
          dut_in_nx = dut_in + N_IN'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      dut_in          <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      state           <= state_nx;
      dut_in          <= dut_in_nx;
      busy            <= busy_nx;
      done            <= done_nx;
      pass            <= pass_nx;
      err_count       <= err_nx;
      first_err_idx   <= fidx_nx;
      first_err_valid <= fval_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gate_bist_checker.sv
// +----------------------------------------------------------------------+
// | tb_gate_bist_checker : scoreboard bench for gate_bist_checker rev 1.0|
// +----------------------------------------------------------------------+
`default_nettype none

module tb_gate_bist_checker;

  typedef struct {
    int errs;
    int fidx;
    int fval;
    int pass;
    int done_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b;
  logic       dut_o_a, dut_o_b;
  logic [1:0] dut_in_a, fidx_a;
  logic [2:0] dut_in_b, fidx_b;
  logic [2:0] err_a;
  logic [3:0] err_b;
  logic       busy_a, done_a, pass_a, fval_a;
  logic       busy_b, done_b, pass_b, fval_b;
  int         mode;
  bit         fault;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  gate_bist_checker u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dut_o(dut_o_a),
    .dut_in(dut_in_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_err_idx(fidx_a), .first_err_valid(fval_a)
  );

  gate_bist_checker #(.N_IN(3), .TRUTH(8'b10010110), .DWELL(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dut_o(dut_o_b),
    .dut_in(dut_in_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_err_idx(fidx_b), .first_err_valid(fval_b)
  );

  // Gates under test: 0=OR, 1=stuck-at-0, 2=AND, 3=NOR; B is XOR3 with optional fault at 6.
  always_comb begin
    case (mode)
      0:       dut_o_a = dut_in_a[0] | dut_in_a[1];
      1:       dut_o_a = 1'b0;
      2:       dut_o_a = dut_in_a[0] & dut_in_a[1];
      default: dut_o_a = ~(dut_in_a[0] | dut_in_a[1]);
    endcase
    dut_o_b = (^dut_in_b) ^ (fault && dut_in_b == 3'd6);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  bit prev_a = 1'b0;
  bit prev_b = 1'b0;

  always @(negedge clk) begin
    if (done_a && !prev_a) begin
      if (qa.size() == 0) chk("a_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_err_count", int'(err_a), e.errs);
        chk("a_first_err_idx", int'(fidx_a), e.fidx);
        chk("a_first_err_valid", int'(fval_a), e.fval);
        chk("a_pass", int'(pass_a), e.pass);
        chk("a_done_cycle", cyc, e.done_cyc);
        chk("a_busy_at_done", int'(busy_a), 0);
      end
    end
    prev_a = done_a;
  end

  always @(negedge clk) begin
    if (done_b && !prev_b) begin
      if (qb.size() == 0) chk("b_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_err_count", int'(err_b), e.errs);
        chk("b_first_err_idx", int'(fidx_b), e.fidx);
        chk("b_first_err_valid", int'(fval_b), e.fval);
        chk("b_pass", int'(pass_b), e.pass);
        chk("b_done_cycle", cyc, e.done_cyc);
      end
    end
    prev_b = done_b;
  end

  // Start accepted at the next posedge; done expected NUM_VEC*(DWELL+1) edges later.
  task automatic run_a(input int errs, input int fidx, input int fval, input int pass);
    exp_t e;
    @(negedge clk);
    start_a = 1'b1;
    e.errs = errs; e.fidx = fidx; e.fval = fval; e.pass = pass;
    e.done_cyc = cyc + 1 + 20;
    qa.push_back(e);
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic run_b(input int errs, input int fidx, input int fval, input int pass);
    exp_t e;
    @(negedge clk);
    start_b = 1'b1;
    e.errs = errs; e.fidx = fidx; e.fval = fval; e.pass = pass;
    e.done_cyc = cyc + 1 + 16;
    qb.push_back(e);
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
    qa.delete();
    qb.delete();
  endtask

  task automatic wait_vec_a(input int v);
    for (int i = 0; i < 50 && int'(dut_in_a) != v; i++) @(negedge clk);
    chk("a_reach_vec", int'(dut_in_a), v);
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_dut_in"}, int'(dut_in_a), 0);
    chk({tag, "_busy"}, int'(busy_a), 0);
    chk({tag, "_done"}, int'(done_a), 0);
    chk({tag, "_pass"}, int'(pass_a), 0);
    chk({tag, "_err"}, int'(err_a), 0);
    chk({tag, "_fidx"}, int'(fidx_a), 0);
    chk({tag, "_fval"}, int'(fval_a), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; mode = 0; fault = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_a("rst");
    chk("rst_b_busy", int'(busy_b), 0);
    chk("rst_b_done", int'(done_b), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ideal OR: dut_in stepping every DWELL+1 cycles.
    run_a(0, 0, 0, 1);
    chk("a_busy_running", int'(busy_a), 1);
    chk("a_vec_t0", int'(dut_in_a), 0);
    repeat (6) @(negedge clk);
    chk("a_vec_t6", int'(dut_in_a), 1);
    repeat (5) @(negedge clk);
    chk("a_vec_t11", int'(dut_in_a), 2);
    repeat (5) @(negedge clk);
    chk("a_vec_t16", int'(dut_in_a), 3);
    drain();

    mode = 1;  // stuck-at-0
    run_a(3, 1, 1, 0);
    drain();
    mode = 2;  // AND against OR table
    run_a(2, 1, 1, 0);
    drain();
    mode = 3;  // NOR: every vector wrong, full-scale count
    run_a(4, 0, 1, 0);
    drain();

    // Restart from DONE clears results; re-pulse while busy is ignored.
    mode = 0;
    run_a(0, 0, 0, 1);
    chk("restart_done_clr", int'(done_a), 0);
    chk("restart_err_clr", int'(err_a), 0);
    chk("restart_fval_clr", int'(fval_a), 0);
    chk("restart_busy", int'(busy_a), 1);
    wait_vec_a(1);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    drain();

    // Reset mid-run aborts; a fresh run then completes cleanly.
    mode = 1;
    run_a(3, 1, 1, 0);
    wait_vec_a(2);
    rst_n = 1'b0;
    qa.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk_zero_a("abort");
    @(negedge clk);
    chk("abort_idle_busy", int'(busy_a), 0);
    mode = 0;
    run_a(0, 0, 0, 1);
    drain();

    // XOR3, DWELL=1: clean, then fault at vector 6.
    fault = 1'b0;
    run_b(0, 0, 0, 1);
    drain();
    fault = 1'b1;
    run_b(1, 6, 1, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
